// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = 4;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned WORD_W          = ADDR_W - 2;
    localparam int unsigned DEF_DEPTH_WORDS = 1024;
    localparam int unsigned DEF_LATENCY     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] word;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port that can be cleared to zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              rd_clr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read data register doubles as the response data; clear wins only when no read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[addr];
        end else if (rd_clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one request in flight, fixed wait latency,
// valid/ready handshake on both sides. Define DMEM_BOUNDS_CHECK_EN to flag
// out-of-range word indices instead of wrapping them.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEF_LATENCY
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [BE_W-1:0]   i_req_be,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_in, req_q, req_cur;
    logic             capture, enter_resp, handshake, cur_oob;
    logic             ram_rd, ram_clr;
    logic [BE_W-1:0]  ram_be;
    logic             unused_bits;

    assign req_in = '{we: i_req_we, word: i_req_addr[ADDR_W-1:2],
                      wdata: i_req_wdata, be: i_req_be};

    // With zero latency the commit edge is the acceptance edge, so use the live request.
    assign req_cur   = (state_q == IDLE) ? req_in : req_q;
    assign handshake = (state_q == RESP) && i_rsp_ready;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign cur_oob = {2'b00, req_cur.word} >= ADDR_W'(DEPTH_WORDS);
`else
    assign cur_oob = 1'b0;
`endif

    assign unused_bits = ^{i_req_addr[1:0], req_cur.word};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    cnt_d      = '0;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset suppresses the commit so a store caught in WAIT never lands.
    assign ram_be  = (enter_resp && req_cur.we && !cur_oob && !i_reset) ? req_cur.be : '0;
    assign ram_rd  = enter_resp && !req_cur.we && !cur_oob && !i_reset;
    assign ram_clr = i_reset || enter_resp || handshake;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            o_req_ready <= (state_d == IDLE);
            o_rsp_valid <= (state_d == RESP);
            if (capture) begin
                req_q <= req_in;
            end
            if (enter_resp) begin
                o_rsp_err <= cur_oob;
            end else if (handshake) begin
                o_rsp_err <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (i_clk),
        .addr   (req_cur.word[AW-1:0]),
        .be     (ram_be),
        .wdata  (req_cur.wdata),
        .rd_en  (ram_rd),
        .rd_clr (ram_clr),
        .rdata  (o_rsp_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic against a word-array reference model, and a zero-latency instance.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk, rst;
    logic        valid, req_ready, we, rsp_valid, rsp_ready, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    logic        z_valid, z_req_ready, z_we, z_rsp_valid, z_rsp_ready, z_err;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [3:0]  z_be;

    int total = 0;
    int bad   = 0;
    logic [31:0] mem_m [int];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_req_valid(valid), .o_req_ready(req_ready),
        .i_req_we(we), .i_req_addr(addr), .i_req_wdata(wdata), .i_req_be(be),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rdata),
        .o_rsp_err(err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(z_valid), .o_req_ready(z_req_ready),
        .i_req_we(z_we), .i_req_addr(z_addr), .i_req_wdata(z_wdata), .i_req_be(z_be),
        .o_rsp_valid(z_rsp_valid), .i_rsp_ready(z_rsp_ready), .o_rsp_rdata(z_rdata),
        .o_rsp_err(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request/response; hold = cycles the response is back-pressured.
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input int hold, input bit stray);
        int unsigned idx, eff;
        bit          oob;
        logic [31:0] exp_rd, cur;
        int          cyc;
        idx = int'(a[31:2]);
        oob = CHECK && (idx >= DEPTH);
        eff = idx % DEPTH;
        exp_rd = 32'h0;
        if (!w && !oob) exp_rd = mem_m.exists(eff) ? mem_m[eff] : 32'h0;

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'h1);
        valid = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        if (w && !oob) begin
            cur = mem_m.exists(eff) ? mem_m[eff] : 32'h0;
            for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
            mem_m[eff] = cur;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            valid = 1'b0;
            cyc++;
        end while (!rsp_valid && cyc < 40);
        check("latency", 32'(cyc), 32'(LAT + 1));

        for (int h = 0; h < hold; h++) begin
            check("hold_rdata", rdata, exp_rd);
            check("hold_ready", {30'h0, req_ready, rsp_valid}, 32'h1);
            if (stray) begin
                valid = 1'b1; we = 1'b1; addr = 32'h3C; wdata = $urandom; be = 4'hF;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        rsp_ready = 1'b1;
        check("rsp_valid", 32'(rsp_valid), 32'h1);
        check("rsp_rdata", rdata, exp_rd);
        check("rsp_err", 32'(err), 32'(oob));
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", {30'h0, req_ready, rsp_valid}, 32'h2);
    endtask

    initial begin
        logic [31:0] zd [4];
        logic [31:0] a;
        int          k, sel;

        rst = 1'b1; valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; rsp_ready = 1'b0;
        z_valid = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0; z_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

        for (int i = 0; i < 16; i++)
            if (i != 4) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);

        txn(1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
        txn(1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b0);

        // Back-pressured load with a competing request that must be ignored.
        txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);
        txn(1'b0, 32'h3C, 32'h0, 4'h0, 0, 1'b0);

        // Reset while a store sits in WAIT.
        @(negedge clk);
        valid = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("wrst_ready", {30'h0, req_ready, rsp_valid}, 32'h2);
        check("wrst_rdata", rdata, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("wrst_quiet", {30'h0, req_ready, rsp_valid}, 32'h2);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

        txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            k   = $urandom_range(15);
            sel = $urandom_range(3);
            if (sel < 2)       a = 32'(k * 4);
            else if (sel == 2) a = 32'((1024 + k) * 4);
            else               a = 32'(($urandom_range(1000, 1) * 1024 + k) * 4);
            a[1:0] = 2'($urandom_range(3));
            txn(1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)),
                $urandom_range(3), 1'b0);
        end

        // Zero-latency instance: back-to-back traffic, one request every 2 cycles.
        z_rsp_ready = 1'b1;
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            check("z_accept_phase", {30'h0, z_req_ready, z_rsp_valid}, 32'h2);
            z_we = (s < 4); z_addr = 32'((s % 4) * 4); z_be = 4'hF; z_valid = 1'b1;
            if (s < 4) zd[s] = $urandom;
            z_wdata = zd[s % 4];
            @(negedge clk);
            check("z_rsp_phase", {30'h0, z_req_ready, z_rsp_valid}, 32'h1);
            check("z_rdata", z_rdata, (s < 4) ? 32'h0 : zd[s % 4]);
        end
        z_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
